nes_calc_ctrl: RTL

- Sequencer for the 4-bit add/sub calculator datapath.
- Turns NES button levels (from the NES reader) into operand entry, operation selection and compute steps.
- Drives the adder/subtractor operands and carry-in, and the result mux select.
- Captures the datapath result and overflow, and supplies the value shown on the seven-segment decoder.

---
 rtl/nes_calc_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/nes_calc_ctrl.sv
// nes_calc_ctrl: sequencer for the 4-bit add/sub calculator.
// Turns NES button levels into operand entry, add/sub selection and compute
// steps. It drives the datapath operands and carry-in, captures the result
// and overflow, and supplies the seven-segment display value.
// Optional build macro NES_CALC_AUTO_REPEAT_EN enables hold-to-repeat on the
// up/down buttons while entering operands.
module nes_calc_ctrl #(
  parameter int unsigned W             = 4,
  parameter int unsigned DP_LAT        = 1,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_a,
  input  logic         btn_b,
  input  logic         btn_select,
  input  logic [W-1:0] dp_result,
  input  logic         dp_cout,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_sub,
  output logic         mux_sel,
  output logic [W-1:0] disp_val,
  output logic [1:0]   state_o,
  output logic         ovf_led,
  output logic         result_valid
);

  if (DP_LAT < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("nes_calc_ctrl: DP_LAT, HOLD_CYCLES and REPEAT_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {StEnterA = 2'd0, StEnterB = 2'd1, StCompute = 2'd2, StShow = 2'd3}
    state_e;

  localparam int unsigned LW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [LW-1:0] LatLast = LW'(DP_LAT - 1);

  state_e        state_q;
  logic [W-1:0]  op_a_q, op_b_q, res_q;
  logic          op_sub_q, ovf_q;
  logic [LW-1:0] lat_q;
  logic          up_q, down_q, a_q, b_q, sel_q;

  logic press_up, press_down, press_a, press_b, press_sel, any_press;
  logic act_a, act_b, act_sel, act_up, act_down;
  logic rep_up, rep_down, step_up, step_down;

  // Rising-edge detect and fixed priority B > A > select > up > down.
  always_comb begin
    press_up   = btn_up & ~up_q;
    press_down = btn_down & ~down_q;
    press_a    = btn_a & ~a_q;
    press_b    = btn_b & ~b_q;
    press_sel  = btn_select & ~sel_q;
    any_press  = press_up | press_down | press_a | press_b | press_sel;
    act_b      = press_b;
    act_a      = press_a & ~press_b;
    act_sel    = press_sel & ~press_a & ~press_b;
    act_up     = press_up & ~press_sel & ~press_a & ~press_b;
    act_down   = press_down & ~press_up & ~press_sel & ~press_a & ~press_b;
    // Repeat steps only fire when no edge is present, so they never collide.
    step_up    = act_up | rep_up;
    step_down  = act_down | rep_down;
  end

`ifdef NES_CALC_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_target;
  logic          rep_phase_q, rep_phase_d;
  logic          up_alone, down_alone, in_entry;

  // Count cycles of a lone held up/down; first step after HOLD, then every REPEAT.
  always_comb begin
    in_entry    = (state_q == StEnterA) || (state_q == StEnterB);
    up_alone    = btn_up & up_q & ~btn_down & ~btn_a & ~btn_b & ~btn_select;
    down_alone  = btn_down & down_q & ~btn_up & ~btn_a & ~btn_b & ~btn_select;
    rep_inc     = rep_cnt_q + 1'b1;
    rep_target  = rep_phase_q ? RW'(REPEAT_CYCLES) : RW'(HOLD_CYCLES);
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    rep_up      = 1'b0;
    rep_down    = 1'b0;
    if (in_entry && !any_press && (up_alone || down_alone)) begin
      if (rep_inc == rep_target) begin
        rep_up      = up_alone;
        rep_down    = down_alone;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_inc;
        rep_phase_d = rep_phase_q;
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
`endif

  // Main sequencer: button history, operands, latency count and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StEnterA;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      op_sub_q <= 1'b0;
      ovf_q    <= 1'b0;
      lat_q    <= '0;
      // Buttons held through reset must be released before they count.
      up_q     <= 1'b1;
      down_q   <= 1'b1;
      a_q      <= 1'b1;
      b_q      <= 1'b1;
      sel_q    <= 1'b1;
    end else begin
      up_q   <= btn_up;
      down_q <= btn_down;
      a_q    <= btn_a;
      b_q    <= btn_b;
      sel_q  <= btn_select;
      unique case (state_q)
        StEnterA: begin
          if (act_b)          op_a_q   <= '0;
          else if (act_a)     state_q  <= StEnterB;
          else if (act_sel)   op_sub_q <= ~op_sub_q;
          else if (step_up)   op_a_q   <= op_a_q + 1'b1;
          else if (step_down) op_a_q   <= op_a_q - 1'b1;
        end
        StEnterB: begin
          if (act_b) begin
            op_b_q  <= '0;
            state_q <= StEnterA;
          end else if (act_a) begin
            lat_q   <= '0;
            state_q <= StCompute;
          end else if (act_sel)   op_sub_q <= ~op_sub_q;
          else if (step_up)       op_b_q   <= op_b_q + 1'b1;
          else if (step_down)     op_b_q   <= op_b_q - 1'b1;
        end
        StCompute: begin
          if (lat_q == LatLast) begin
            res_q   <= dp_result;
            // Subtraction borrows when there is no carry-out.
            ovf_q   <= op_sub_q ? ~dp_cout : dp_cout;
            state_q <= StShow;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StShow: begin
          if (act_b) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StEnterA;
          end else if (act_a) begin
            op_a_q  <= res_q;
            op_b_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= StEnterB;
          end
        end
        default: state_q <= StEnterA;
      endcase
    end
  end

  // Display follows the operand being edited, then the captured result.
  always_comb begin
    unique case (state_q)
      StEnterA: disp_val = op_a_q;
      StShow:   disp_val = res_q;
      default:  disp_val = op_b_q;
    endcase
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_sub       = op_sub_q;
  assign mux_sel      = op_sub_q;
  assign ovf_led      = ovf_q;
  assign state_o      = state_q;
  assign result_valid = (state_q == StShow);

endmodule
